// File: rtl/child_generator_if.sv
// Parent hand-off, status-memory read port and candidate bus of the A* child generator.
// The master modport is the generator's view; slave is the surrounding expansion stage.
interface child_generator_if #(
    parameter int COORD_W = 6,
    parameter int G_W     = 12
);
    logic                 parent_valid;
    logic                 parent_ready;
    logic [COORD_W-1:0]   parent_x;
    logic [COORD_W-1:0]   parent_y;
    logic [G_W-1:0]       parent_g;

    logic                 mem_rd_en;
    logic [2*COORD_W-1:0] mem_rd_addr;
    logic [G_W+2:0]       mem_rd_data;

    logic [COORD_W-1:0]   child_x;
    logic [COORD_W-1:0]   child_y;
    logic [G_W-1:0]       children_g;
    logic                 children_v;
    logic                 open_list;
    logic                 close_list;
    logic [G_W-1:0]       open_list_g_int;
    logic                 expand_done;

    modport master (
        input  parent_valid, parent_x, parent_y, parent_g, mem_rd_data,
        output parent_ready, mem_rd_en, mem_rd_addr,
        output child_x, child_y, children_g, children_v,
        output open_list, close_list, open_list_g_int, expand_done
    );

    modport slave (
        output parent_valid, parent_x, parent_y, parent_g, mem_rd_data,
        input  parent_ready, mem_rd_en, mem_rd_addr,
        input  child_x, child_y, children_g, children_v,
        input  open_list, close_list, open_list_g_int, expand_done
    );
endinterface

// File: rtl/child_generator.sv
// A* child generator: walks the N/E/S/W neighbours of one parent, reads each in-bounds
// neighbour's status word and presents non-obstacle neighbours to the validator.
module child_generator #(
    parameter int COORD_W   = 6,
    parameter int G_W       = 12,
    parameter int STEP_COST = 1
) (
    input logic               clock,
    input logic               reset,
    child_generator_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state, state_next;

    logic [COORD_W-1:0] px, py;
    logic [G_W-1:0]     pg;
    logic [1:0]         idx;
    logic               idx_last;

    logic [COORD_W-1:0] cx, cy;
    logic               nbr_ok;
    logic               rd_en;

    logic [G_W:0]       g_sum;
    logic [G_W-1:0]     g_sat;

    logic               obstacle;
    logic               rd_open;
    logic               rd_close;
    logic [G_W-1:0]     rd_g;

    logic [COORD_W-1:0] cand_x, cand_y;
    logic [G_W-1:0]     cand_g, cand_sg;
    logic               cand_open, cand_close, cand_v;

    assign idx_last = (idx == 2'd3);

    assign obstacle = bus.mem_rd_data[G_W+2];
    assign rd_open  = bus.mem_rd_data[G_W+1];
    assign rd_close = bus.mem_rd_data[G_W];
    assign rd_g     = bus.mem_rd_data[G_W-1:0];

    // Neighbour order N, E, S, W; grid edges are hard limits, no wrap-around.
    always_comb begin
        cx     = px;
        cy     = py;
        nbr_ok = 1'b1;
        case (idx)
            2'd0: begin
                cy     = py - COORD_W'(1);
                nbr_ok = (py != '0);
            end
            2'd1: begin
                cx     = px + COORD_W'(1);
                nbr_ok = (px != '1);
            end
            2'd2: begin
                cy     = py + COORD_W'(1);
                nbr_ok = (py != '1);
            end
            default: begin
                cx     = px - COORD_W'(1);
                nbr_ok = (px != '0);
            end
        endcase
    end

    always_comb begin
        g_sum = {1'b0, pg} + (G_W+1)'(STEP_COST);
        g_sat = g_sum[G_W] ? '1 : g_sum[G_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.parent_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (nbr_ok) begin
                    state_next = WAIT;
                end else if (idx_last) begin
                    state_next = DONE;
                end
            end
            WAIT: begin
                state_next = idx_last ? DONE : ISSUE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.parent_ready = (state == IDLE);
        rd_en            = (state == ISSUE) && nbr_ok;
        bus.mem_rd_en    = rd_en;
        bus.mem_rd_addr  = rd_en ? {cy, cx} : '0;
        bus.expand_done  = (state == DONE);
    end

    // Candidate data persists between pulses; only cand_v is cleared each cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            px         <= '0;
            py         <= '0;
            pg         <= '0;
            idx        <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            cand_g     <= '0;
            cand_sg    <= '0;
            cand_open  <= 1'b0;
            cand_close <= 1'b0;
            cand_v     <= 1'b0;
        end else begin
            cand_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.parent_valid) begin
                        px  <= bus.parent_x;
                        py  <= bus.parent_y;
                        pg  <= bus.parent_g;
                        idx <= '0;
                    end
                end
                ISSUE: begin
                    if (!nbr_ok) begin
                        idx <= idx + 2'd1;
                    end
                end
                WAIT: begin
                    idx <= idx + 2'd1;
                    if (!obstacle) begin
                        cand_x     <= cx;
                        cand_y     <= cy;
                        cand_g     <= g_sat;
                        cand_open  <= rd_open;
                        cand_close <= rd_close;
                        cand_sg    <= rd_g;
                        cand_v     <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.child_x         = cand_x;
    assign bus.child_y         = cand_y;
    assign bus.children_g      = cand_g;
    assign bus.open_list       = cand_open;
    assign bus.close_list      = cand_close;
    assign bus.open_list_g_int = cand_sg;
    assign bus.children_v      = cand_v;
endmodule

// File: tb/tb_child_generator.sv
// Bench for child_generator: random status memory and parents, checked cycle by cycle
// against a neighbour-walk model that derives read/candidate/done timing arithmetically.
module tb_child_generator;
    localparam int CW   = 6;
    localparam int GW   = 12;
    localparam int STEP = 1;
    localparam int GRID = 64;
    localparam int GMAX = 4095;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    child_generator_if #(.COORD_W(CW), .G_W(GW)) bus ();

    child_generator #(.COORD_W(CW), .G_W(GW), .STEP_COST(STEP)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [GW+2:0] mem [GRID*GRID];
    logic [GW+2:0] fill;
    logic [37:0]   last_cand;
    int errors = 0;
    int checks = 0;

    always @(posedge clock) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.mem_rd_en, bus.children_v, bus.expand_done, bus.parent_ready};
    endfunction

    function automatic logic [37:0] cand_now();
        return {bus.child_x, bus.child_y, bus.children_g, bus.open_list,
                bus.close_list, bus.open_list_g_int};
    endfunction

    task automatic put(input int x, input int y, input logic [GW+2:0] v);
        mem[y*GRID + x] = v;
    endtask

    // Cycle 0 is the accepting cycle; observes cycles 1..done+1 at negedges.
    task automatic expand(input int x, input int y, input int g, input bit hold,
                          input int nx, input int ny, input int ng);
        int dxs[4] = '{0, 1, 0, -1};
        int dys[4] = '{-1, 0, 1, 0};
        bit rd[32];
        bit cv[32];
        int addr[32];
        logic [37:0] cand[32];
        logic [GW+2:0] e;
        logic [3:0] ef;
        int t, cx, cy, cg;
        for (int i = 0; i < 32; i++) begin
            rd[i] = 1'b0; cv[i] = 1'b0; addr[i] = 0; cand[i] = '0;
        end
        cg = (g + STEP > GMAX) ? GMAX : g + STEP;
        t = 1;
        for (int i = 0; i < 4; i++) begin
            cx = x + dxs[i];
            cy = y + dys[i];
            if (cx < 0 || cx >= GRID || cy < 0 || cy >= GRID) begin
                t = t + 1;
            end else begin
                rd[t]   = 1'b1;
                addr[t] = cy*GRID + cx;
                e       = mem[addr[t]];
                if (!e[GW+2]) begin
                    cv[t+2]   = 1'b1;
                    cand[t+2] = {6'(cx), 6'(cy), 12'(cg), e[GW+1], e[GW], e[GW-1:0]};
                end
                t = t + 2;
            end
        end
        for (int k = 1; k <= t + 1; k++) begin
            @(negedge clock);
            if (cv[k]) last_cand = cand[k];
            ef = {rd[k], cv[k], (k == t), (k == t + 1)};
            check_eq($sformatf("flags p(%0d,%0d,%0d) c%0d", x, y, g, k), 64'(flags_now()), 64'(ef));
            if (rd[k])
                check_eq($sformatf("addr p(%0d,%0d) c%0d", x, y, k), 64'(bus.mem_rd_addr), 64'(addr[k]));
            check_eq($sformatf("cand p(%0d,%0d,%0d) c%0d", x, y, g, k), 64'(cand_now()), 64'(last_cand));
            if (k == 1) begin
                if (hold) begin
                    bus.parent_x = 6'(nx);
                    bus.parent_y = 6'(ny);
                    bus.parent_g = 12'(ng);
                end else begin
                    bus.parent_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!bus.parent_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_eq("ready_wait", 64'(bus.parent_ready), 64'd1);
    endtask

    task automatic offer(input int x, input int y, input int g, input bit hold,
                         input int nx, input int ny, input int ng);
        wait_ready();
        bus.parent_x     = 6'(x);
        bus.parent_y     = 6'(y);
        bus.parent_g     = 12'(g);
        bus.parent_valid = 1'b1;
        expand(x, y, g, hold, nx, ny, ng);
    endtask

    task automatic free_around(input int x, input int y);
        put(x, y-1, '0); put(x+1, y, '0); put(x, y+1, '0); put(x-1, y, '0);
    endtask

    initial begin
        int x, y, g;
        bus.parent_valid = 1'b0;
        bus.parent_x     = '0;
        bus.parent_y     = '0;
        bus.parent_g     = '0;
        bus.mem_rd_data  = '0;
        last_cand        = '0;
        for (int i = 0; i < GRID*GRID; i++) begin
            fill       = 15'($urandom);
            fill[GW+2] = ($urandom_range(0, 3) == 0);
            mem[i]     = fill;
        end

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("reset_flags", 64'(flags_now()), 64'b0001);
        check_eq("reset_cand", 64'(cand_now()), 64'd0);
        reset = 1'b0;

        free_around(10, 10);
        offer(10, 10, 5, 0, 0, 0, 0);

        put(1, 0, '0); put(0, 1, '0);
        offer(0, 0, 0, 0, 0, 0, 0);

        free_around(10, 10);
        put(11, 10, 15'h4000);
        offer(10, 10, 20, 0, 0, 0, 0);

        free_around(10, 10);
        put(10, 9, 15'h2007);
        put(10, 11, 15'h1123);
        offer(10, 10, GMAX, 0, 0, 0, 0);

        // Reset lands in cycle 4 of an interior expansion.
        free_around(10, 10);
        wait_ready();
        bus.parent_x = 6'd10; bus.parent_y = 6'd10; bus.parent_g = 12'd5;
        bus.parent_valid = 1'b1;
        @(negedge clock); bus.parent_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        last_cand = '0;
        for (int k = 5; k <= 12; k++) begin
            if (k > 5) @(negedge clock);
            check_eq($sformatf("rst_flags c%0d", k), 64'(flags_now()), 64'b0001);
            check_eq($sformatf("rst_cand c%0d", k), 64'(cand_now()), 64'd0);
        end
        offer(10, 10, 5, 0, 0, 0, 0);

        // parent_valid held across three back-to-back parents.
        offer(20, 30, 100, 1, 63, 5, 4094);
        expand(63, 5, 4094, 1, 0, 63, 7);
        expand(0, 63, 7, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            x = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 63 : 0) : int'($urandom_range(0, 63));
            y = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 63 : 0) : int'($urandom_range(0, 63));
            g = $urandom_range(0, 1) ? int'($urandom_range(4090, 4095)) : int'($urandom_range(0, 4095));
            offer(x, y, g, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
